// File: rtl/enc_pkg.sv
// enc_pkg: shared state encoding and width check for the enc_scan_n index serialiser.
package enc_pkg;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_FIN = 2'd2} state_t;
   function automatic bit fits_width(input int n, input int w);
      return n >= 2 && n <= (1 << w);
   endfunction
endpackage

// File: rtl/enc_scan_n_if.sv
// enc_scan_n_if: request capture and index valid/ready bundle for enc_scan_n.
interface enc_scan_n_if #(parameter int N = 8, parameter int W = 3);
   logic         en;
   logic         load;
   logic [N-1:0] a;
   logic         y_ready;
   logic [W-1:0] y;
   logic         y_valid;
   logic [W:0]   cnt;
   logic         busy;
   logic         done;
   modport master(output en, load, a, y_ready, input y, y_valid, cnt, busy, done);
   modport slave(input en, load, a, y_ready, output y, y_valid, cnt, busy, done);
endinterface

// File: rtl/enc_prio_n.sv
// enc_prio_n: combinational priority encoder, lowest or highest set bit per MSB_FIRST.
module enc_prio_n #(
   parameter int N         = 8,
   parameter int W         = 3,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic [N-1:0] i_pend,
   output logic [W-1:0] o_idx,
   output logic         o_any
);
   // Later iterations override earlier ones, so the walk runs toward the winning end.
   always_comb begin
      o_idx = '0;
      for (int i = 0; i < N; i++)
         if (i_pend[MSB_FIRST ? i : N - 1 - i]) o_idx = W'(MSB_FIRST ? i : N - 1 - i);
   end
   assign o_any = |i_pend;
endmodule

// File: rtl/enc_scan_n.sv
// enc_scan_n: captures an N-bit request vector and streams its set-bit indices over valid/ready.
// Define ENC_SCAN_MSB_FIRST_EN to emit the highest index first instead of the lowest.
module enc_scan_n
   import enc_pkg::*;
#(
   parameter int N = 8,
   parameter int W = 3
) (
   input logic         clk,
   input logic         rst,
   enc_scan_n_if.slave io_enc
);
   if (!fits_width(N, W)) begin : g_chk
      $error("enc_scan_n: need 2 <= N <= 2**W");
   end
`ifdef ENC_SCAN_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif
   state_t       r_state, w_nxt;
   logic [N-1:0] r_pend, w_clr;
   logic [W:0]   r_cnt;
   logic [W-1:0] w_idx;
   logic         w_any, w_busy, w_load, w_xfer, w_last;

   enc_prio_n #(.N(N), .W(W), .MSB_FIRST(MSB_FIRST)) u_prio (
      .i_pend(r_pend),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign w_busy = r_state == ST_SCAN;
   assign w_load = r_state == ST_IDLE && io_enc.en && io_enc.load;
   assign w_xfer = w_busy && w_any && io_enc.y_ready && io_enc.en;
   assign w_clr  = N'(1) << w_idx;
   assign w_last = ~|(r_pend & ~w_clr);

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_nxt;

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         ST_IDLE: w_nxt = w_load ? (|io_enc.a ? ST_SCAN : ST_FIN) : ST_IDLE;
         ST_SCAN: w_nxt = w_xfer && w_last ? ST_FIN : ST_SCAN;
         ST_FIN:  w_nxt = io_enc.en ? ST_IDLE : ST_FIN;
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      io_enc.busy    = w_busy;
      io_enc.y_valid = w_busy;
      io_enc.y       = w_busy ? w_idx : '0;
      io_enc.done    = r_state == ST_FIN && io_enc.en;
      io_enc.cnt     = r_cnt;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_pend <= '0;
         r_cnt  <= '0;
      end else if (w_load) begin
         r_pend <= io_enc.a;
         r_cnt  <= '0;
      end else if (w_xfer) begin
         r_pend <= r_pend & ~w_clr;
         r_cnt  <= r_cnt == (W+1)'(N) ? r_cnt : r_cnt + 1'b1;
      end
endmodule
